// File: rtl/seq_mult_hs.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_hs
//  Description : Iterative shift-add multiplier, signed or unsigned, with
//                valid/ready handshakes on operand and result sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_hs #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               slow_clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_result;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_out_valid;

    logic                 w_accept;
    logic                 w_out_fire;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH+STEP-1:0] w_pp;
    logic [WIDTH+STEP-1:0] w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_out_fire = r_out_valid && out_ready;
    assign w_last     = (r_cnt == CW'(1));

    // Magnitudes fit WIDTH unsigned bits, including the most-negative operand.
    assign w_mag_a = (signed_mode && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    assign w_mag_b = (signed_mode && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

    assign w_pp  = {{WIDTH{1'b0}}, r_mplier[STEP-1:0]} * {{STEP{1'b0}}, r_mcand};
    assign w_sum = {{STEP{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_pp;

    generate
        if (STEP < WIDTH) begin : g_shift
            assign w_acc_next = {w_sum, r_acc[WIDTH-1:STEP]};
        end else begin : g_single
            assign w_acc_next = w_sum;
        end
    endgenerate

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_state_next = DONE;
            end
            DONE: begin
                if (w_out_fire) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= CW'(N);
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> STEP;
                    r_cnt    <= r_cnt - CW'(1);
                end
                FIX: begin
                    // Negating a zero product yields zero, so no special case.
                    r_result    <= r_neg ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_hs.sv
`default_nettype none
// Bench for seq_mult_hs: two instances (STEP=1 and STEP=4), randomized and
// directed operations checked by a queue-based scoreboard.
module tb_seq_mult_hs;

    localparam int W = 32;

    logic slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    logic [1:0]          rst = 2'b11;
    logic [1:0]          in_valid;
    logic [1:0]          in_ready;
    logic [1:0][W-1:0]   a;
    logic [1:0][W-1:0]   b;
    logic [1:0]          signed_mode;
    logic [1:0]          out_valid;
    logic [1:0]          out_ready;
    logic [1:0][2*W-1:0] result;
    logic [1:0]          busy;

    seq_mult_hs #(.WIDTH(W), .STEP(1)) u_dut_s1 (
        .slow_clk(slow_clk), .rst(rst[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .signed_mode(signed_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .result(result[0]), .busy(busy[0])
    );

    seq_mult_hs #(.WIDTH(W), .STEP(4)) u_dut_s4 (
        .slow_clk(slow_clk), .rst(rst[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .signed_mode(signed_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .result(result[1]), .busy(busy[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge slow_clk) cyc <= cyc + 1;

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    logic [1:0]        in_flight = '0;
    logic [1:0]        prev_ov   = '0;
    logic [1:0]        hold      = '0;
    logic [1:0][63:0]  prev_res  = '0;
    int                acc_cyc [2];

    task automatic chk(input string nm, input int d, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s [dut%0d]: actual %h required %h", nm, d, got, exp);
        end
    endtask

    task automatic timeout_fail(input string nm, input int d);
        n_cmp++;
        n_bad++;
        $display("FAIL %s [dut%0d]: actual timeout required handshake", nm, d);
    endtask

    // Reference: plain integer arithmetic on the operands as presented.
    function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        longint sx, sy;
        if (sm) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic int latency(input int d);
        return (d == 0) ? (W / 1 + 1) : (W / 4 + 1);
    endfunction

    always @(negedge slow_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                chk("rst_out_valid", d, out_valid[d], 1'b0);
                chk("rst_result",    d, result[d],    64'd0);
                chk("rst_busy",      d, busy[d],      1'b0);
                chk("rst_in_ready",  d, in_ready[d],  1'b1);
                in_flight[d] = 1'b0;
                prev_ov[d]   = 1'b0;
                hold[d]      = 1'b0;
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                chk("busy",     d, busy[d],     in_flight[d]);
                chk("in_ready", d, in_ready[d], !in_flight[d]);
                if (hold[d]) begin
                    chk("hold_out_valid", d, out_valid[d], 1'b1);
                    chk("hold_result",    d, result[d],    prev_res[d]);
                end
                if (out_valid[d] && !prev_ov[d])
                    chk("latency", d, 64'(cyc - acc_cyc[d]), 64'(latency(d)));
                if (out_valid[d] && out_ready[d]) begin
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        timeout_fail("unexpected_output", d);
                    end else begin
                        chk("result", d, result[d], (d == 0) ? q0.pop_front() : q1.pop_front());
                    end
                    in_flight[d] = 1'b0;
                end
                if (in_valid[d] && in_ready[d]) begin
                    if (d == 0) q0.push_back(model(a[d], b[d], signed_mode[d]));
                    else        q1.push_back(model(a[d], b[d], signed_mode[d]));
                    in_flight[d] = 1'b1;
                    acc_cyc[d]   = cyc + 1;
                end
                hold[d]     = out_valid[d] && !out_ready[d];
                prev_ov[d]  = out_valid[d];
                prev_res[d] = result[d];
            end
        end
    end

    // Returns just after the accept edge, with the operand bus scrambled.
    task automatic issue(input int d, input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        int n;
        @(posedge slow_clk);
        #1;
        a[d] = x; b[d] = y; signed_mode[d] = sm;
        in_valid[d] = 1'b1; out_ready[d] = 1'b0;
        n = 0;
        do begin
            @(negedge slow_clk);
            n++;
        end while (!in_ready[d] && n < 200);
        if (!in_ready[d]) timeout_fail("in_ready_timeout", d);
        @(posedge slow_clk);
        #1;
        in_valid[d] = 1'b0;
        a[d] = $urandom; b[d] = $urandom; signed_mode[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out(input int d);
        int n;
        n = 0;
        do begin
            @(negedge slow_clk);
            n++;
        end while (!out_valid[d] && n < 100);
        if (!out_valid[d]) timeout_fail("out_valid_timeout", d);
    endtask

    task automatic run_op(input int d, input logic [W-1:0] x, input logic [W-1:0] y, input logic sm, input int bp);
        issue(d, x, y, sm);
        wait_out(d);
        @(posedge slow_clk);
        repeat (bp) @(posedge slow_clk);
        #1 out_ready[d] = 1'b1;
        @(posedge slow_clk);
        #1 out_ready[d] = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        in_valid = '0; out_ready = '0; a = '0; b = '0; signed_mode = '0;
        repeat (3) @(posedge slow_clk);
        #1 rst = 2'b00;
        @(negedge slow_clk);
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_out_valid", d, out_valid[d], 1'b0);
            chk("post_rst_result",    d, result[d],    64'd0);
        end

        run_op(0, 32'd5, 32'd6, 1'b0, 0);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2);
        run_op(0, 32'hFFFF_FFFD, 32'd7, 1'b1, 0);
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1);
        run_op(0, 32'h8000_0000, 32'd1, 1'b1, 0);
        run_op(0, 32'h8000_0000, 32'd1, 1'b0, 0);
        run_op(0, 32'd0, 32'h8000_0001, 1'b1, 0);

        // Backpressure with a competing request that must be ignored.
        issue(0, 32'hDEAD_BEEF, 32'h0001_2345, 1'b1);
        wait_out(0);
        @(posedge slow_clk);
        #1;
        in_valid[0] = 1'b1; a[0] = 32'd9; b[0] = 32'd9; signed_mode[0] = 1'b0;
        repeat (10) @(posedge slow_clk);
        #1 in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge slow_clk);
        #1 out_ready[0] = 1'b0;
        @(negedge slow_clk);
        chk("in_ready_after_bp", 0, in_ready[0], 1'b1);

        // Abort mid-calculation on the STEP=4 instance.
        issue(1, $urandom, $urandom, 1'b0);
        repeat (4) @(posedge slow_clk);
        #1 rst[1] = 1'b1;
        repeat (2) @(posedge slow_clk);
        #1 rst[1] = 1'b0;
        @(negedge slow_clk);
        chk("abort_out_valid", 1, out_valid[1], 1'b0);
        chk("abort_result",    1, result[1],    64'd0);
        run_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                run_op(d, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            end
        end

        @(negedge slow_clk);
        chk("scoreboard_empty", 0, 64'(q0.size()), 64'd0);
        chk("scoreboard_empty", 1, 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
- Parametrised iterative multiplier. Multiplies two WIDTH-bit operands as signed or unsigned, using shift-add on STEP multiplier bits per cycle.
- Valid/ready handshake on both the input and the output side; the result is held under backpressure.
- Runs entirely in the slow_clk domain and replaces the fixed 32-bit register-wrapped combinational multiplier.
- Sits between an operand source and a result consumer, both of which use valid/ready.

Parameters:
- WIDTH, 32, operand width in bits; must be at least 2.
- STEP, 1, multiplier bits consumed per CALC cycle; legal values are 1, 2 and 4, and STEP must divide WIDTH.
- N = WIDTH/STEP is derived, not a parameter. It is the number of CALC cycles.

Ports:
- slow_clk  in  1  block clock, all state on its rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a and b
- out_valid  out  1  result is available
- out_ready  in  1  consumer accepts the result
- result  out  2*WIDTH  product
- busy  out  1  high in CALC, FIX and DONE

Behaviour:
- Reset: rst asynchronous, active-high; clock slow_clk. While rst is high and after it is released:
  - state = IDLE
  - out_valid = 0, result = 0, busy = 0
  - accumulator, counter and sign flag cleared
  - in_ready = 1 (in_ready is the IDLE decode)
- rst asserted at any point, including mid-CALC or in DONE, aborts the operation with no partial output. The next operation after reset is computed correctly.
- States are IDLE, CALC, FIX, DONE. Outputs by state:
  - in_ready = (state == IDLE)
  - busy = !IDLE
- IDLE: an accept happens on a rising edge where in_valid && in_ready.
  - Capture the operand magnitudes. If signed_mode is set, take the two's-complement absolute value of each operand that has its MSB set; otherwise capture a and b unchanged.
  - neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the accumulator, load the counter with N, go to CALC.
- CALC: each cycle, add (low STEP bits of the multiplier) × (multiplicand) into the upper accumulator. Then shift the accumulator and the multiplier right by STEP and decrement the counter. When the counter reaches 1, go to FIX. There is no early termination on zero operands.
- FIX: one cycle.
  - result <= neg ? (2*WIDTH-bit two's-complement negation of the product) : product.
  - out_valid <= 1, go to DONE.
- DONE: result and out_valid are held stable until out_valid && out_ready. On that edge, out_valid <= 0 and the state returns to IDLE. result keeps its last value and is not cleared.
- Latency: out_valid rises exactly N+1 cycles after the accept edge (33 for WIDTH=32, STEP=1; 9 for STEP=4).
- Throughput: with out_ready tied high, one operation per N+3 cycles. in_ready is high on the cycle after the output handshake.
- in_valid outside IDLE is ignored. Changes on a, b or signed_mode after the accept do not affect the operation in flight.
- Width rules:
  - A magnitude is at most 2^(WIDTH-1) in signed mode and fits in WIDTH unsigned bits.
  - The product always fits in 2*WIDTH bits, so there is no overflow flag.
  - neg with a zero product yields 0.
  - The most-negative operand is handled without special casing: (-2^(W-1))² = 2^(2W-2).
- out_ready asserted while out_valid = 0 has no effect.

Test Plan:
- Reset: hold rst for 3 cycles, release → out_valid=0, result=0, busy=0, in_ready=1. Then run a=5, b=6 unsigned → result=30.
- Unsigned max (W=32, S=1): a=b=0xFFFFFFFF, signed_mode=0 → result=0xFFFFFFFE00000001. out_valid rises exactly 33 cycles after the accept edge, and busy is high throughout.
- Signed mixed: a=0xFFFFFFFD (-3), b=7, signed_mode=1 → 0xFFFFFFFFFFFFFFEB.
- Signed extremes:
  - a=b=0x80000000, signed → 0x4000000000000000.
  - a=0x80000000, b=1, signed → 0xFFFFFFFF80000000; the same operands unsigned → 0x0000000080000000.
- Backpressure: out_ready=0 for 10 cycles after out_valid → result and out_valid stable, in_ready=0. A concurrent in_valid with a=9, b=9 is ignored. Then out_ready=1 → in_ready=1 on the next cycle.
- Mid-op reset and STEP=4: with STEP=4, assert rst 4 cycles into CALC → all outputs return to reset values. A fresh a=0x12345678, b=0x9ABCDEF0 unsigned → 0x0B00EA4E242D2080 with out_valid 9 cycles after the accept edge.
